// File: rtl/insn_fetch_unit.sv
// insn_fetch_unit: sequential instruction fetcher feeding a valid/ready consumer.
//
// The fetcher drives an instruction memory that has one cycle of latency. The
// memory registers imemAddr at a clock edge and returns the instruction on
// imemInsn in the following cycle. fetchPC always holds the address of the
// instruction currently on imemInsn. That is why outPC equals fetchPC and
// outInsn equals imemInsn.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   imemAddr          word-aligned byte address to instruction memory
//   imemInsn          instruction for the previous cycle's imemAddr
//   redirectValid/PC  branch/jump redirect (PC[1:0] ignored); highest priority
//   haltReq           stop fetching after the current RUN cycle
//   outValid/Ready    handshake towards the consumer
//   outInsn/outPC     fetched instruction and its address
//   fetchCount        accepted instructions (perf counters build only, else 0)
//   stallCount        RUN cycles with outValid && !outReady (same build, else 0)
//
// Build option: define IFETCH_PERF_CNT_EN to include the two performance
// counters. When it is undefined, both counter outputs are tied to zero.
module insn_fetch_unit #(
  parameter int INSN_ADDR_WIDTH = 32,
  parameter int INSN_WIDTH      = 32,
  parameter logic [INSN_ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [INSN_ADDR_WIDTH-1:0] imemAddr,
  input  logic [INSN_WIDTH-1:0]      imemInsn,
  input  logic                       redirectValid,
  input  logic [INSN_ADDR_WIDTH-1:0] redirectPC,
  input  logic                       haltReq,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [INSN_WIDTH-1:0]      outInsn,
  output logic [INSN_ADDR_WIDTH-1:0] outPC,
  output logic [31:0]                fetchCount,
  output logic [31:0]                stallCount
);

  typedef enum logic [1:0] {FILL, RUN, HALT} state_t;

  state_t                     state;
  logic [INSN_ADDR_WIDTH-1:0] fetch_pc;
  logic [INSN_ADDR_WIDTH-1:0] pc_inc;
  logic [INSN_ADDR_WIDTH-1:0] redir_pc;
  logic                       accept;

  // The low target bits are discarded, so every fetch address is word-aligned.
  wire unused_redir_lsbs = ^redirectPC[1:0];

  assign redir_pc = {redirectPC[INSN_ADDR_WIDTH-1:2], 2'b00};
  assign pc_inc   = fetch_pc + INSN_ADDR_WIDTH'(4);   // wraps at 2^W

  // outValid depends only on state and redirectValid, never on outReady.
  assign outValid = (state == RUN) && !redirectValid;
  assign accept   = outValid && outReady;
  assign outPC    = fetch_pc;
  assign outInsn  = imemInsn;

  // imemAddr is the fetchPC of the next cycle. The memory latches it at the
  // same edge where fetch_pc takes this value.
  always_comb begin
    imemAddr = fetch_pc;
    if (!rst)               imemAddr = RESET_PC;
    else if (redirectValid) imemAddr = redir_pc;
    else if (accept)        imemAddr = pc_inc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FILL;
      fetch_pc <= RESET_PC;
    end else if (redirectValid) begin
      // The target is latched by the memory at this edge, so the next cycle
      // can be RUN without an extra FILL bubble.
      state    <= RUN;
      fetch_pc <= redir_pc;
    end else begin
      case (state)
        FILL: state <= RUN;
        RUN: begin
          if (accept)  fetch_pc <= pc_inc;
          if (haltReq) state    <= HALT;
        end
        HALT: ;                           // wait for a redirect
        default: state <= FILL;
      endcase
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      // accept already excludes redirect cycles, because outValid is low then.
      if (accept)                            fetch_cnt <= fetch_cnt + 32'd1;
      if (state == RUN && outValid && !outReady) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign fetchCount = fetch_cnt;
  assign stallCount = stall_cnt;
`else
  assign fetchCount = '0;
  assign stallCount = '0;
`endif

endmodule

// File: tb/tb_insn_fetch_unit.sv
// Bench for insn_fetch_unit with RESET_PC = 0x100.
// A one-cycle-latency memory model returns ins_of(addr). Expected accepted PCs
// are queued as the stimulus is driven. They are popped and checked whenever
// the DUT completes a handshake. Counter expectations fall to zero when the
// perf counter build option is undefined.
module tb_insn_fetch_unit;

  localparam logic [31:0] RPC = 32'h100;
`ifdef IFETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imemAddr;
  logic [31:0] imemInsn = '0;
  logic        redirectValid;
  logic [31:0] redirectPC;
  logic        haltReq;
  logic        outValid;
  logic        outReady;
  logic [31:0] outInsn;
  logic [31:0] outPC;
  logic [31:0] fetchCount;
  logic [31:0] stallCount;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  insn_fetch_unit #(.INSN_ADDR_WIDTH(32), .INSN_WIDTH(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .imemAddr(imemAddr), .imemInsn(imemInsn),
    .redirectValid(redirectValid), .redirectPC(redirectPC), .haltReq(haltReq),
    .outValid(outValid), .outReady(outReady), .outInsn(outInsn), .outPC(outPC),
    .fetchCount(fetchCount), .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return (a ^ 32'h5A5A_C3C3) + 32'h0001_0000;
  endfunction

  // Instruction memory: latches the address at posedge and returns data in the next cycle.
  always @(posedge clk) imemInsn <= ins_of(imemAddr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  // Scoreboard: every handshake must match the next queued PC.
  always @(negedge clk) begin
    if (rst && outValid && outReady) begin
      if (exp_q.size() == 0) chk("sb_unexpected", outPC, 32'hDEAD_BEEF);
      else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", outPC, e);
        chk("sb_insn", outInsn, ins_of(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #50000;
    $display("FAIL timeout got=%0t exp=<50000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; outReady = 1'b1; redirectValid = 1'b0; redirectPC = '0; haltReq = 1'b0;
    @(negedge clk);
    chk("rst_vld", outValid, 0);
    chk("rst_addr", imemAddr, RPC);
    chk("rst_fcnt", fetchCount, 0);
    chk("rst_scnt", stallCount, 0);

    // Release: FILL cycle, then stream 0x100, 0x104.
    tick(); rst = 1'b1; haltReq = 1'b1;     // haltReq must be ignored in FILL
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    @(negedge clk);
    chk("fill_vld", outValid, 0);
    chk("fill_addr", imemAddr, 32'h100);
    tick(); haltReq = 1'b0;
    @(negedge clk);
    chk("run1_vld", outValid, 1);
    chk("run1_addr", imemAddr, 32'h104);

    // Stall three cycles on 0x104.
    tick(); outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      chk("stall_vld", outValid, 1);
      chk("stall_pc", outPC, 32'h104);
      chk("stall_insn", outInsn, ins_of(32'h104));
      chk("stall_addr", imemAddr, 32'h104);
    end
    tick(); outReady = 1'b1;
    chk("stall_scnt", stallCount, cnt(3));
    chk("stall_fcnt", fetchCount, cnt(1));

    // Redirect to 0x203 while 0x108 is presented.
    tick(); redirectValid = 1'b1; redirectPC = 32'h203;
    @(negedge clk);
    chk("redir_vld", outValid, 0);
    chk("redir_pc", outPC, 32'h108);
    chk("redir_addr", imemAddr, 32'h200);
    tick(); redirectValid = 1'b0; haltReq = 1'b1;
    exp_q.push_back(32'h200);
    chk("redir_fcnt", fetchCount, cnt(2));
    @(negedge clk);
    chk("halt_acc_vld", outValid, 1);

    // HALT: idle until redirect, haltReq ignored.
    tick(); haltReq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("halt_vld", outValid, 0);
      chk("halt_addr", imemAddr, 32'h204);
      tick();
    end
    chk("halt_fcnt", fetchCount, cnt(3));
    redirectValid = 1'b1; redirectPC = 32'h40;
    @(negedge clk);
    chk("hredir_addr", imemAddr, 32'h40);
    tick(); redirectValid = 1'b0;
    exp_q.push_back(32'h40); exp_q.push_back(32'h44);
    @(negedge clk);
    tick();
    @(negedge clk);

    // Wrap from the top of the address space.
    tick(); redirectValid = 1'b1; redirectPC = 32'hFFFF_FFFE;
    @(negedge clk);
    chk("wrap_redir_addr", imemAddr, 32'hFFFF_FFFC);
    tick(); redirectValid = 1'b0;
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    @(negedge clk);
    chk("wrap_addr", imemAddr, 32'h0);
    tick(); @(negedge clk);
    tick(); @(negedge clk);
    tick(); outReady = 1'b0;
    @(negedge clk);
    chk("wrap_stall_pc", outPC, 32'h8);
    chk("wrap_fcnt", fetchCount, cnt(8));
    chk("wrap_scnt", stallCount, cnt(3));
    chk("sb_drained", 32'(exp_q.size()), 0);

    // Asynchronous reset in the middle of a stall.
    #2 rst = 1'b0;
    #1;
    chk("arst_vld", outValid, 0);
    chk("arst_addr", imemAddr, RPC);
    chk("arst_fcnt", fetchCount, 0);
    chk("arst_scnt", stallCount, 0);
    tick(); rst = 1'b1; outReady = 1'b1;
    exp_q.push_back(32'h100);
    @(negedge clk);
    chk("refill_vld", outValid, 0);
    tick(); @(negedge clk);
    tick(); outReady = 1'b0;
    @(negedge clk);
    chk("re_pc", outPC, 32'h104);
    chk("re_fcnt", fetchCount, cnt(1));
    chk("sb_final", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/insn_fetch_unit.md
INSN_FETCH_UNIT -- requirements
Module: insn_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset (word-aligned).
REQ-002 SHALL have port clk  input  1  clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port imemAddr  output  INSN_ADDR_WIDTH  byte address to instruction memory, latched by memory at posedge; data returns next cycle.
REQ-005 SHALL have port imemInsn  input  INSN_WIDTH  instruction for the address presented in the previous cycle.
REQ-006 SHALL have port redirectValid  input  1  branch/jump redirect request.
REQ-007 SHALL have port redirectPC  input  INSN_ADDR_WIDTH  redirect target.
REQ-008 SHALL have port haltReq  input  1  stop fetching after current instruction.
REQ-009 SHALL have port outValid  output  1  outInsn/outPC valid.
REQ-010 SHALL have port outReady  input  1  consumer accepts when outValid && outReady.
REQ-011 SHALL have port outInsn  output  INSN_WIDTH  fetched instruction (= imemInsn).
REQ-012 SHALL have port outPC  output  INSN_ADDR_WIDTH  address of outInsn.
REQ-013 SHALL have ports fetchCount, stallCount  output  32 each  performance counters.

Function
REQ-014 SHALL hold fetchPC register = address whose instruction is currently on imemInsn.
REQ-015 SHALL implement states FILL, RUN, HALT.
REQ-016 FILL: outValid=0; imemAddr=fetchPC; next state RUN.
REQ-017 RUN: outValid=1 unless redirectValid; outPC=fetchPC; outInsn=imemInsn.
REQ-018 RUN accept (outValid && outReady): imemAddr=fetchPC+4, fetchPC<=fetchPC+4.
REQ-019 RUN not accepted: imemAddr=fetchPC, fetchPC held, so outInsn/outPC stay stable while stalled.
REQ-020 redirectValid in any state SHALL take priority: outValid=0 that cycle, imemAddr={redirectPC[hi:2],2'b00}, fetchPC<=same, next state RUN; no bubble.
REQ-021 redirectPC[1:0] SHALL be ignored (forced 0).
REQ-022 haltReq in RUN without redirect: current handshake completes normally; next state HALT regardless of acceptance.
REQ-023 HALT: outValid=0, imemAddr=fetchPC, fetchPC held; haltReq ignored; exit only via redirect.
REQ-024 haltReq in FILL SHALL be ignored.
REQ-025 fetchPC+4 SHALL wrap modulo 2^INSN_ADDR_WIDTH (0xFFFFFFFC -> 0x0).
REQ-026 outValid SHALL depend combinationally only on state and redirectValid; no dependency on outReady.

Reset
REQ-027 rst low SHALL asynchronously set state=FILL, fetchPC=RESET_PC, fetchCount=0, stallCount=0.
REQ-028 During reset outValid=0, imemAddr=RESET_PC.
REQ-029 First valid instruction SHALL appear at outValid in the second cycle after rst deasserts (FILL then RUN).
REQ-030 Reset mid-stall or mid-halt SHALL discard all state; no accept in that cycle is counted.

Configuration
REQ-031 Macro IFETCH_PERF_CNT_EN: when defined, fetchCount increments on each accept (not during redirect), stallCount increments each RUN cycle with outValid && !outReady; both wrap at 2^32.
REQ-032 Without IFETCH_PERF_CNT_EN, fetchCount and stallCount SHALL be constant 0 and no counter registers exist; all other behaviour identical.

Verification
REQ-033 RESET_PC=0x100, rst released, outReady=1 -> cycle1 outValid=0; cycles 2..4 outPC=0x100,0x104,0x108 with matching imemInsn.
REQ-034 outReady=0 for 3 cycles at outPC=0x104 -> outPC/outInsn held 0x104, imemAddr=0x104; stallCount +3 (macro on).
REQ-035 redirectValid with redirectPC=0x203 while outValid at 0x108 and outReady=1 -> outValid=0 that cycle, next cycle outPC=0x200; fetchCount not incremented for 0x108.
REQ-036 haltReq with outReady=1 at 0x200 -> 0x200 accepted, then outValid=0 indefinitely; redirect to 0x40 -> next cycle outPC=0x40.
REQ-037 Redirect to 0xFFFFFFFC, outReady=1 -> outPC 0xFFFFFFFC then 0x00000000.
REQ-038 Build without IFETCH_PERF_CNT_EN, repeat REQ-034 -> fetchCount=stallCount=0, handshake trace identical.
